// File: rtl/fetch_buffer_nway.sv
// N-wide fetch stage: holds the PC, fetches FETCH_WIDTH sequential words per cycle
// into a circular instruction queue, and presents up to FETCH_WIDTH oldest entries to decode.
module fetch_buffer_nway #(
  parameter int          FETCH_WIDTH = 2,
  parameter int          QDEPTH      = 8,
  parameter logic [31:0] RESET_PC    = 32'h0,
  localparam int FW  = FETCH_WIDTH,
  localparam int PSW = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1,
  localparam int CW  = $clog2(QDEPTH + 1),
  localparam int AW  = $clog2(QDEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic [31:0]       imem_addr,
  input  logic [32*FW-1:0]  imem_rdata,
  input  logic              pred_taken,
  input  logic [PSW-1:0]    pred_slot,
  input  logic [31:0]       pred_target,
  output logic [31:0]       pcf,
  output logic [FW-1:0]     deq_valid,
  output logic [32*FW-1:0]  deq_instr,
  output logic [32*FW-1:0]  deq_pc,
  output logic [FW-1:0]     deq_pred_taken,
  output logic [CW-1:0]     q_count
);

  logic [31:0]   pcf_q, pcf_d;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [31:0] instr_mem [QDEPTH];
  logic [31:0] pc_mem    [QDEPTH];
  logic        pred_mem  [QDEPTH];

  logic          fe;
  logic [CW-1:0] enq_n, deq_n;
  logic [FW-1:0] wr_en;
  logic [AW-1:0] wr_idx [FW];

  // Fetch is throttled on the registered count only, so stall has no path into fetch.
  always_comb begin
    fe      = !redirect_valid && (int'(count_q) <= QDEPTH - FW);
    enq_n   = '0;
    deq_n   = '0;
    if (fe)
      enq_n = pred_taken ? CW'(pred_slot) + CW'(1) : CW'(FW);
    if (!stall && !redirect_valid)
      deq_n = (count_q < CW'(FW)) ? count_q : CW'(FW);

    for (int i = 0; i < FW; i++) begin
      wr_en[i]  = fe && (CW'(i) < enq_n);
      wr_idx[i] = tail_q + AW'(i);
    end

    head_d  = head_q + AW'(deq_n);
    tail_d  = tail_q + AW'(enq_n);
    count_d = count_q + enq_n - deq_n;
    pcf_d   = pcf_q;
    if (redirect_valid) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      pcf_d   = {redirect_pc[31:2], 2'b00};
    end else if (fe && pred_taken) begin
      pcf_d   = {pred_target[31:2], 2'b00};
    end else if (fe) begin
      pcf_d   = pcf_q + 32'(4 * FW);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcf_q   <= {RESET_PC[31:2], 2'b00};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      pcf_q   <= pcf_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: queue storage is not reset; entries are only ever read when count_q marks them valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FW; i++) begin
      if (wr_en[i]) begin
        instr_mem[wr_idx[i]] <= imem_rdata[32*i +: 32];
        pc_mem[wr_idx[i]]    <= pcf_q + 32'(4 * i);
        pred_mem[wr_idx[i]]  <= pred_taken && (int'(pred_slot) == i);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < FW; i++) begin
      deq_valid[i]         = (int'(count_q) > i) && !redirect_valid;
      deq_instr[32*i +: 32] = instr_mem[head_q + AW'(i)];
      deq_pc[32*i +: 32]    = pc_mem[head_q + AW'(i)];
      deq_pred_taken[i]    = pred_mem[head_q + AW'(i)];
    end
  end

  assign imem_addr = pcf_q;
  assign pcf       = pcf_q;
  assign q_count   = count_q;

endmodule

// File: tb/tb_fetch_buffer_nway.sv
// Directed bench for fetch_buffer_nway with FW=2, QDEPTH=8, RESET_PC=0; the
// instruction memory returns a fixed scramble of each word address.
module tb_fetch_buffer_nway;
  localparam int FW = 2;
  localparam int QD = 8;

  logic        clk = 1'b0;
  logic        reset, stall, redirect_valid, pred_taken;
  logic [31:0] redirect_pc, pred_target, imem_addr, pcf;
  logic [0:0]  pred_slot;
  logic [63:0] imem_rdata, deq_instr, deq_pc;
  logic [1:0]  deq_valid, deq_pred_taken;
  logic [3:0]  q_count;

  int total = 0;
  int bad   = 0;

  fetch_buffer_nway #(.FETCH_WIDTH(FW), .QDEPTH(QD), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .pred_taken(pred_taken), .pred_slot(pred_slot), .pred_target(pred_target),
    .pcf(pcf), .deq_valid(deq_valid), .deq_instr(deq_instr), .deq_pc(deq_pc),
    .deq_pred_taken(deq_pred_taken), .q_count(q_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  always_comb
    for (int i = 0; i < FW; i++) imem_rdata[32*i +: 32] = word_at(imem_addr + 32'(4 * i));

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; pred_taken = 1'b0; pred_slot = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (pcf !== 32'h0) begin bad++; $display("FAIL reset_pcf got=%h exp=%h", pcf, 32'h0); end
    total++; if (q_count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", q_count); end
    total++; if (deq_valid !== 2'b00) begin bad++; $display("FAIL reset_valid got=%b exp=00", deq_valid); end
  endtask

  task automatic test_stream();
    logic [31:0] e;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      total++; if (pcf !== 32'(8 * k)) begin bad++; $display("FAIL stream_pcf k=%0d got=%h exp=%h", k, pcf, 32'(8 * k)); end
      if (k > 0) begin
        e = 32'(8 * (k - 1));
        total++; if (deq_valid !== 2'b11) begin bad++; $display("FAIL stream_valid k=%0d got=%b exp=11", k, deq_valid); end
        total++; if (deq_pc !== {e + 32'h4, e}) begin bad++; $display("FAIL stream_pc k=%0d got=%h exp=%h", k, deq_pc, {e + 32'h4, e}); end
        total++; if (deq_instr[31:0] !== word_at(e)) begin bad++; $display("FAIL stream_instr k=%0d got=%h exp=%h", k, deq_instr[31:0], word_at(e)); end
        total++; if (q_count !== 4'd2) begin bad++; $display("FAIL stream_count k=%0d got=%0d exp=2", k, q_count); end
      end
      step();
    end
  endtask

  task automatic test_stall_fill();
    int ec, ep;
    logic [31:0] e;
    do_reset();
    stall = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      ec = (2 * k > 8) ? 8 : 2 * k;
      ep = (8 * k > 32) ? 32 : 8 * k;
      total++; if (q_count !== 4'(ec)) begin bad++; $display("FAIL fill_count k=%0d got=%0d exp=%0d", k, q_count, ec); end
      total++; if (pcf !== 32'(ep)) begin bad++; $display("FAIL fill_pcf k=%0d got=%h exp=%h", k, pcf, 32'(ep)); end
      if (k < 6) step();
    end
    stall = 1'b0;
    for (int j = 0; j < 6; j++) begin
      e = 32'(8 * j);
      total++; if (deq_pc !== {e + 32'h4, e} || deq_valid !== 2'b11) begin
        bad++; $display("FAIL drain_pc j=%0d got=%h/%b exp=%h/11", j, deq_pc, deq_valid, {e + 32'h4, e});
      end
      if (j == 1) begin
        total++; if (pcf !== 32'h20) begin bad++; $display("FAIL drain_pcf_hold got=%h exp=%h", pcf, 32'h20); end
        total++; if (q_count !== 4'd6) begin bad++; $display("FAIL drain_count got=%0d exp=6", q_count); end
      end
      if (j == 2) begin
        total++; if (pcf !== 32'h28) begin bad++; $display("FAIL drain_pcf_resume got=%h exp=%h", pcf, 32'h28); end
      end
      step();
    end
  endtask

  task automatic test_pred_taken();
    do_reset();
    step(); step();
    total++; if (pcf !== 32'h10) begin bad++; $display("FAIL pred_setup_pcf got=%h exp=%h", pcf, 32'h10); end
    pred_taken = 1'b1; pred_slot = 1'b0; pred_target = 32'h40;
    step();
    pred_taken = 1'b0;
    total++; if (pcf !== 32'h40) begin bad++; $display("FAIL pred0_pcf got=%h exp=%h", pcf, 32'h40); end
    total++; if (q_count !== 4'd1) begin bad++; $display("FAIL pred0_count got=%0d exp=1", q_count); end
    total++; if (deq_valid !== 2'b01) begin bad++; $display("FAIL pred0_valid got=%b exp=01", deq_valid); end
    total++; if (deq_pc[31:0] !== 32'h10) begin bad++; $display("FAIL pred0_pc got=%h exp=%h", deq_pc[31:0], 32'h10); end
    total++; if (deq_pred_taken[0] !== 1'b1) begin bad++; $display("FAIL pred0_flag got=%b exp=1", deq_pred_taken[0]); end
    step();
    total++; if (deq_pc !== {32'h44, 32'h40}) begin bad++; $display("FAIL pred0_after_pc got=%h exp=%h", deq_pc, {32'h44, 32'h40}); end
    total++; if (deq_pred_taken !== 2'b00) begin bad++; $display("FAIL pred0_after_flag got=%b exp=00", deq_pred_taken); end
    total++; if (pcf !== 32'h48) begin bad++; $display("FAIL pred0_after_pcf got=%h exp=%h", pcf, 32'h48); end
    // Slot-1 prediction keeps the whole group; misaligned target is word-aligned on load.
    pred_taken = 1'b1; pred_slot = 1'b1; pred_target = 32'h83;
    step();
    pred_taken = 1'b0;
    total++; if (deq_pc !== {32'h4C, 32'h48}) begin bad++; $display("FAIL pred1_pc got=%h exp=%h", deq_pc, {32'h4C, 32'h48}); end
    total++; if (deq_pred_taken !== 2'b10) begin bad++; $display("FAIL pred1_flag got=%b exp=10", deq_pred_taken); end
    total++; if (pcf !== 32'h80) begin bad++; $display("FAIL pred1_pcf got=%h exp=%h", pcf, 32'h80); end
  endtask

  task automatic test_redirect();
    do_reset();
    stall = 1'b1; pred_taken = 1'b1; pred_slot = 1'b0; pred_target = 32'h200;
    step();
    pred_taken = 1'b0;
    step(); step();
    total++; if (q_count !== 4'd5) begin bad++; $display("FAIL redir_setup_count got=%0d exp=5", q_count); end
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    #1;
    total++; if (deq_valid !== 2'b00) begin bad++; $display("FAIL redir_same_valid got=%b exp=00", deq_valid); end
    step();
    redirect_valid = 1'b0; stall = 1'b0;
    #1;
    total++; if (q_count !== 4'd0) begin bad++; $display("FAIL redir_count got=%0d exp=0", q_count); end
    total++; if (pcf !== 32'h100) begin bad++; $display("FAIL redir_pcf got=%h exp=%h", pcf, 32'h100); end
    total++; if (deq_valid !== 2'b00) begin bad++; $display("FAIL redir_next_valid got=%b exp=00", deq_valid); end
    step();
    total++; if (deq_valid !== 2'b11 || deq_pc !== {32'h104, 32'h100}) begin
      bad++; $display("FAIL redir_first_deq got=%h/%b exp=%h/11", deq_pc, deq_valid, {32'h104, 32'h100});
    end
  endtask

  task automatic test_random_stall();
    int mcount, ndeq, nenq;
    logic [31:0] exp_pc;
    logic [1:0]  ev;
    do_reset();
    mcount = 0;
    exp_pc = 32'h0;
    for (int c = 0; c < 40; c++) begin
      stall = 1'($urandom_range(0, 1));
      ev = (mcount >= 2) ? 2'b11 : (mcount == 1) ? 2'b01 : 2'b00;
      total++; if (q_count !== 4'(mcount)) begin bad++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, q_count, mcount); end
      total++; if (deq_valid !== ev) begin bad++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, deq_valid, ev); end
      for (int i = 0; i < FW; i++) begin
        if (ev[i]) begin
          total++; if (deq_pc[32*i +: 32] !== exp_pc + 32'(4 * i) || deq_instr[32*i +: 32] !== word_at(exp_pc + 32'(4 * i))) begin
            bad++; $display("FAIL rnd_slot c=%0d i=%0d got_pc=%h exp_pc=%h", c, i, deq_pc[32*i +: 32], exp_pc + 32'(4 * i));
          end
        end
      end
      ndeq = stall ? 0 : ((mcount < FW) ? mcount : FW);
      nenq = (mcount <= QD - FW) ? FW : 0;
      exp_pc = exp_pc + 32'(4 * ndeq);
      mcount = mcount + nenq - ndeq;
      step();
    end
    stall = 1'b0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    stall = 1'b1;
    step(); step(); step();
    total++; if (q_count !== 4'd6) begin bad++; $display("FAIL mreset_setup_count got=%0d exp=6", q_count); end
    reset = 1'b1;
    step();
    reset = 1'b0; stall = 1'b0;
    #1;
    total++; if (q_count !== 4'd0) begin bad++; $display("FAIL mreset_count got=%0d exp=0", q_count); end
    total++; if (deq_valid !== 2'b00) begin bad++; $display("FAIL mreset_valid got=%b exp=00", deq_valid); end
    total++; if (pcf !== 32'h0) begin bad++; $display("FAIL mreset_pcf got=%h exp=%h", pcf, 32'h0); end
    step();
    total++; if (deq_pc !== {32'h4, 32'h0} || q_count !== 4'd2) begin
      bad++; $display("FAIL mreset_refetch got=%h/%0d exp=%h/2", deq_pc, q_count, {32'h4, 32'h0});
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    pred_taken = 1'b0; pred_slot = 1'b0; pred_target = '0;
    test_reset();
    test_stream();
    test_stall_fill();
    test_pred_taken();
    test_redirect();
    test_random_stall();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
